id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the 16-bit five-stage pipeline. It sits directly downstream of the instruction-fetch stage and its IF/ID buffer. It decodes the buffered instruction and reads operands from an internal 16×16 register file. It resolves branches and jumps in ID, detects load-use and branch-operand hazards, drives the fetch stage's PC and buffer controls, and registers its results into the ID/EX pipeline buffer.

## Interface
Parameters:
- DATA_W, 16, datapath and instruction width
- NREG, 16, register-file depth; register-address width is log2(NREG) = 4

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- InstIn  in  16  instruction from the IF/ID buffer
- PCplus2In  in  16  PC+2 from the IF/ID buffer
- wbRegWrite  in  1  write-back enable
- wbRd  in  4  write-back register
- wbData  in  16  write-back data
- exmemRd  in  4  destination register of the instruction in MEM
- exmemMemRead  in  1  instruction in MEM is a load
- pcWrite  out  1  to IF; 0 holds the PC
- enable  out  1  to IF; 0 holds the IF/ID buffer
- flush  out  1  to IF; 1 zeroes the IF/ID buffer at the next edge
- sel  out  1  to IF; 1 selects branchtoPC as the next PC
- branchtoPC  out  16  branch or jump target
- idexRegWrite, idexMemRead, idexMemWrite, idexAluSrc  out  1 each  registered controls
- idexFunct  out  4  registered ALU function
- idexRd, idexRs  out  4 each  registered register numbers
- idexOp1, idexOp2, idexImm  out  16 each  registered operands and extended immediate

## Operation
Instruction fields: opcode = [15:12], r1 = [11:8], r2 = [7:4], funct = [3:0].
- 0000 R-type: r1 ← r1 funct r2. Sets RegWrite.
- 1000 LW: r1 ← MEM[r2 + zext([3:0])]. Sets MemRead, RegWrite and AluSrc.
- 1011 SW: MEM[r2 + zext([3:0])] ← r1. Sets MemWrite and AluSrc.
- 0100 BZ: taken if RF[r1] == 0. Target = PCplus2In + (sext([7:0]) << 1).
- 0101 BNZ: taken if RF[r1] != 0. Same target as BZ.
- 1100 JMP: always taken. Target = PCplus2In + (sext([11:0]) << 1).
- Any other opcode, and 16'h0000, is a NOP: all controls 0.

Address arithmetic is modulo 2^16; carries out of bit 15 are dropped.

Register file:
- Two asynchronous read ports, one synchronous write port.
- Write-through: when wbRegWrite = 1 and wbRd matches a read address, the read returns wbData in the same cycle.
- Register 0 is an ordinary register.

Hazard unit, combinational; stall = 1 when any of the following holds:
- Load-use: idexMemRead = 1 and idexRd equals any register the current instruction reads.
  - R-type reads r1 and r2. LW reads r2. SW reads r1 and r2. BZ/BNZ read r1.
- Branch operand from EX: current instruction is BZ/BNZ, idexRegWrite = 1 and idexRd == r1.
- Branch operand from MEM: current instruction is BZ/BNZ, exmemMemRead = 1 and exmemRd == r1.

Output control:
- On stall: pcWrite = 0, enable = 0, flush = 0, sel = 0. ID/EX loads a bubble (all idex controls 0).
- On taken branch/jump with no stall: sel = 1, flush = 1, pcWrite = 1, enable = 1. The branch itself enters ID/EX as a NOP.
- Otherwise: pcWrite = 1, enable = 1, flush = 0, sel = 0. ID/EX loads the decoded instruction.
- Stall has priority over branch resolution; a stalled branch never asserts sel.

## Timing
- Reset (asynchronous) clears all 16 registers and every idex output to 0.
- While rst = 1, the combinational outputs settle to pcWrite = 1, enable = 1, flush = 0, sel = 0, branchtoPC = target of the decoded InstIn.
- Decode-to-ID/EX latency is 1 cycle.
- Branch penalty: 1 cycle. The flushed slot appears in IF/ID as 16'h0000.
- Load-use stall: 1 cycle. A branch on a load result stalls 2 cycles: one while the load is in EX, one while it is in MEM.
- A register-file write and a dependent read in the same cycle see the new value (write-through). WB never causes a stall.
- If rst asserts mid-stall, the stall is abandoned. Register-file contents are lost.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BZ, OP_BNZ, OP_JMP);
  - the funct code constants;
  - DATA_W and the register-address width.
- One sub-module: reg_file (16×16, two async read ports, one write port, write-through, asynchronous reset).
- The decoder, hazard unit and ID/EX register live in id_stage.

## Test plan
- Reset, then R-type 16'h0120 with R1 = 5, R2 = 3 → next edge: idexRegWrite = 1, idexOp1 = 5, idexOp2 = 3, idexFunct = 0, idexRd = 1.
- Write-through: wbRegWrite = 1, wbRd = 2, wbData = 16'h00AA, with InstIn = 16'h0120 → idexOp2 = 16'h00AA at the same edge.
- Load-use: LW 16'h8130 enters EX, then R-type 16'h0210 in ID → one cycle of pcWrite = 0, enable = 0 and a bubble in ID/EX, then normal issue.
- BZ 16'h4304, R3 = 0, PCplus2In = 16'h0010 → sel = 1, flush = 1, branchtoPC = 16'h0018. Same with R3 = 1 → sel = 0, flush = 0.
- JMP 16'hCFFE, PCplus2In = 16'h0002 → branchtoPC = 16'hFFFE (modulo wrap). rst asserted mid-stall → all idex outputs 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes, funct codes and the ID/EX record
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int NREG   = 16;
   localparam int REG_AW = 4;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_LW    = 4'b1000;
   localparam logic [3:0] OP_SW    = 4'b1011;
   localparam logic [3:0] OP_BZ    = 4'b0100;
   localparam logic [3:0] OP_BNZ   = 4'b0101;
   localparam logic [3:0] OP_JMP   = 4'b1100;

   localparam logic [3:0] FN_ADD = 4'h0;
   localparam logic [3:0] FN_SUB = 4'h1;
   localparam logic [3:0] FN_AND = 4'h2;
   localparam logic [3:0] FN_OR  = 4'h3;
   localparam logic [3:0] FN_XOR = 4'h4;
   localparam logic [3:0] FN_SLL = 4'h5;
   localparam logic [3:0] FN_SRL = 4'h6;
   localparam logic [3:0] FN_SLT = 4'h7;

   // Everything the ID/EX buffer carries; an all-zero value is a bubble.
   typedef struct packed {
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              alu_src;
      logic [3:0]        funct;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [DATA_W-1:0] imm;
   } idex_t;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file, two async read ports, write-through write port
module reg_file #(
   parameter int DATA_W = 16,
   parameter int NREG   = 16,
   parameter int AW     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     i_ra1,
   input  logic [AW-1:0]     i_ra2,
   input  logic              i_we,
   input  logic [AW-1:0]     i_wa,
   input  logic [DATA_W-1:0] i_wd,
   output logic [DATA_W-1:0] o_rd1,
   output logic [DATA_W-1:0] o_rd2
);

   logic [DATA_W-1:0] r_mem [NREG];

   // Storage: cleared on reset, one write per cycle from write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   // Write-through bypass so WB and a dependent decode can share a cycle.
   assign o_rd1 = (i_we && (i_wa == i_ra1)) ? i_wd : r_mem[i_ra1];
   assign o_rd2 = (i_we && (i_wa == i_ra2)) ? i_wd : r_mem[i_ra2];

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode, operand read, branch resolve, hazard detect, ID/EX buffer
module id_stage #(
   parameter int DATA_W = 16,
   parameter int NREG   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] InstIn,
   input  logic [DATA_W-1:0] PCplus2In,
   input  logic              wbRegWrite,
   input  logic [3:0]        wbRd,
   input  logic [DATA_W-1:0] wbData,
   input  logic [3:0]        exmemRd,
   input  logic              exmemMemRead,
   output logic              pcWrite,
   output logic              enable,
   output logic              flush,
   output logic              sel,
   output logic [DATA_W-1:0] branchtoPC,
   output logic              idexRegWrite,
   output logic              idexMemRead,
   output logic              idexMemWrite,
   output logic              idexAluSrc,
   output logic [3:0]        idexFunct,
   output logic [3:0]        idexRd,
   output logic [3:0]        idexRs,
   output logic [DATA_W-1:0] idexOp1,
   output logic [DATA_W-1:0] idexOp2,
   output logic [DATA_W-1:0] idexImm
);
   import cpu_pkg::*;

   idex_t             r_idex;
   idex_t             w_dec;
   logic [3:0]        w_op;
   logic [3:0]        w_r1;
   logic [3:0]        w_r2;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_off;
   logic w_is_r, w_is_lw, w_is_sw, w_is_bz, w_is_bnz, w_is_jmp, w_is_br;
   logic w_reads_r1, w_reads_r2;
   logic w_load_use, w_br_haz, w_stall, w_taken;

   assign w_op = InstIn[15:12];
   assign w_r1 = InstIn[11:8];
   assign w_r2 = InstIn[7:4];

   reg_file #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
      .clk   (clk),
      .rst   (rst),
      .i_ra1 (w_r1),
      .i_ra2 (w_r2),
      .i_we  (wbRegWrite),
      .i_wa  (wbRd),
      .i_wd  (wbData),
      .o_rd1 (w_a),
      .o_rd2 (w_b)
   );

   // The all-zero word has the R-type opcode but is a NOP.
   assign w_is_r   = (w_op == OP_RTYPE) && (InstIn != '0);
   assign w_is_lw  = (w_op == OP_LW);
   assign w_is_sw  = (w_op == OP_SW);
   assign w_is_bz  = (w_op == OP_BZ);
   assign w_is_bnz = (w_op == OP_BNZ);
   assign w_is_jmp = (w_op == OP_JMP);
   assign w_is_br  = w_is_bz || w_is_bnz;

   assign w_reads_r1 = w_is_r || w_is_sw || w_is_br;
   assign w_reads_r2 = w_is_r || w_is_lw || w_is_sw;

   assign w_load_use = r_idex.mem_read &&
                       ((w_reads_r1 && (r_idex.rd == w_r1)) ||
                        (w_reads_r2 && (r_idex.rd == w_r2)));
   assign w_br_haz   = w_is_br &&
                       ((r_idex.reg_write && (r_idex.rd == w_r1)) ||
                        (exmemMemRead && (exmemRd == w_r1)));
   assign w_stall    = !rst && (w_load_use || w_br_haz);
   assign w_taken    = !rst && (w_is_jmp || (w_is_bz && (w_a == '0)) ||
                                (w_is_bnz && (w_a != '0)));

   // JMP uses a 12-bit word offset, conditional branches an 8-bit one.
   assign w_off      = w_is_jmp ? {{(DATA_W-13){InstIn[11]}}, InstIn[11:0], 1'b0}
                                : {{(DATA_W-9){InstIn[7]}}, InstIn[7:0], 1'b0};
   assign branchtoPC = PCplus2In + w_off;

   // Fetch control: a stall freezes IF and wins over a taken branch.
   always_comb begin
      pcWrite = 1'b1;
      enable  = 1'b1;
      flush   = 1'b0;
      sel     = 1'b0;
      if (w_stall) begin
         pcWrite = 1'b0;
         enable  = 1'b0;
      end else if (w_taken) begin
         flush = 1'b1;
         sel   = 1'b1;
      end
   end

   // Decode into the ID/EX record; branches and NOPs carry nothing forward.
   always_comb begin
      w_dec = '0;
      if (w_is_r || w_is_lw || w_is_sw) begin
         w_dec.rd  = w_r1;
         w_dec.rs  = w_r2;
         w_dec.op1 = w_a;
         w_dec.op2 = w_b;
      end
      if (w_is_r) begin
         w_dec.reg_write = 1'b1;
         w_dec.funct     = InstIn[3:0];
      end else if (w_is_lw || w_is_sw) begin
         w_dec.reg_write = w_is_lw;
         w_dec.mem_read  = w_is_lw;
         w_dec.mem_write = w_is_sw;
         w_dec.alu_src   = 1'b1;
         w_dec.funct     = FN_ADD;
         w_dec.imm       = {{(DATA_W-4){1'b0}}, InstIn[3:0]};
      end
   end

   // ID/EX buffer: bubble on stall or taken branch, else the decoded record.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idex <= '0;
      end else if (w_stall || w_taken) begin
         r_idex <= '0;
      end else begin
         r_idex <= w_dec;
      end
   end

   assign idexRegWrite = r_idex.reg_write;
   assign idexMemRead  = r_idex.mem_read;
   assign idexMemWrite = r_idex.mem_write;
   assign idexAluSrc   = r_idex.alu_src;
   assign idexFunct    = r_idex.funct;
   assign idexRd       = r_idex.rd;
   assign idexRs       = r_idex.rs;
   assign idexOp1      = r_idex.op1;
   assign idexOp2      = r_idex.op2;
   assign idexImm      = r_idex.imm;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] InstIn, PCplus2In, wbData, branchtoPC;
   logic        wbRegWrite, exmemMemRead;
   logic [3:0]  wbRd, exmemRd;
   logic        pcWrite, enable, flush, sel;
   logic        idexRegWrite, idexMemRead, idexMemWrite, idexAluSrc;
   logic [3:0]  idexFunct, idexRd, idexRs;
   logic [15:0] idexOp1, idexOp2, idexImm;

   id_stage dut (
      .clk(clk), .rst(rst), .InstIn(InstIn), .PCplus2In(PCplus2In),
      .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData),
      .exmemRd(exmemRd), .exmemMemRead(exmemMemRead),
      .pcWrite(pcWrite), .enable(enable), .flush(flush), .sel(sel),
      .branchtoPC(branchtoPC),
      .idexRegWrite(idexRegWrite), .idexMemRead(idexMemRead),
      .idexMemWrite(idexMemWrite), .idexAluSrc(idexAluSrc),
      .idexFunct(idexFunct), .idexRd(idexRd), .idexRs(idexRs),
      .idexOp1(idexOp1), .idexOp2(idexOp2), .idexImm(idexImm)
   );

   always #5 clk = ~clk;

   // Record layout: rw mr mw as | funct | rd | rs | op1 | op2 | imm
   wire [63:0] w_obs = {idexRegWrite, idexMemRead, idexMemWrite, idexAluSrc,
                        idexFunct, idexRd, idexRs, idexOp1, idexOp2, idexImm};
   wire [19:0] w_ctl = {pcWrite, enable, flush, sel, branchtoPC};

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [15:0] m_rf [16];
   logic [63:0] m_idex;
   logic [63:0] sb [$];
   logic [19:0] ctl_seen;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [15:0] m_read(input logic [3:0] a);
      return (wbRegWrite && wbRd == a) ? wbData : m_rf[a];
   endfunction

   task automatic step(input string tag, input logic [15:0] inst, input logic [15:0] pc2,
                       input logic we, input logic [3:0] wrd, input logic [15:0] wd,
                       input logic [3:0] exrd, input logic exmr);
      logic [3:0]  op, r1, r2;
      logic [15:0] a, b, off, tgt;
      logic        isr, islw, issw, isbz, isbnz, isj, rd1, rd2, stall, taken;
      logic [19:0] exp_c;
      logic [63:0] nxt;
      @(negedge clk);
      InstIn = inst; PCplus2In = pc2; wbRegWrite = we; wbRd = wrd; wbData = wd;
      exmemRd = exrd; exmemMemRead = exmr;
      #1;
      op = inst[15:12]; r1 = inst[11:8]; r2 = inst[7:4];
      a = m_read(r1); b = m_read(r2);
      isr = (op == 4'h0) && (inst != 16'h0000);
      islw = (op == 4'h8); issw = (op == 4'hB);
      isbz = (op == 4'h4); isbnz = (op == 4'h5); isj = (op == 4'hC);
      rd1 = isr | issw | isbz | isbnz;
      rd2 = isr | islw | issw;
      stall = (m_idex[62] && ((rd1 && m_idex[55:52] == r1) || (rd2 && m_idex[55:52] == r2)))
            || ((isbz | isbnz) && ((m_idex[63] && m_idex[55:52] == r1) || (exmr && exrd == r1)));
      taken = isj || (isbz && a == 16'h0) || (isbnz && a != 16'h0);
      off = isj ? {{3{inst[11]}}, inst[11:0], 1'b0} : {{7{inst[7]}}, inst[7:0], 1'b0};
      tgt = pc2 + off;
      exp_c = stall ? {4'b0000, tgt} : taken ? {4'b1111, tgt} : {4'b1100, tgt};
      ctl_seen = w_ctl;
      check({tag, ".ctl"}, 64'(w_ctl), 64'(exp_c));
      if (stall || taken) nxt = '0;
      else if (isr)  nxt = {4'b1000, inst[3:0], r1, r2, a, b, 16'h0000};
      else if (islw) nxt = {4'b1101, 4'h0, r1, r2, a, b, 12'h000, inst[3:0]};
      else if (issw) nxt = {4'b0011, 4'h0, r1, r2, a, b, 12'h000, inst[3:0]};
      else nxt = '0;
      sb.push_back(nxt);
      @(posedge clk);
      #1;
      if (we) m_rf[wrd] = wd;
      m_idex = sb.pop_front();
      check({tag, ".idex"}, w_obs, m_idex);
   endtask

   initial begin
      rst = 1'b1; InstIn = 16'hC003; PCplus2In = 16'h0100;
      wbRegWrite = 1'b0; wbRd = 4'h0; wbData = 16'h0; exmemRd = 4'h0; exmemMemRead = 1'b0;
      for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
      m_idex = '0;
      #2;
      check("rst_idex", w_obs, 64'h0);
      check("rst_ctl", 64'(w_ctl), 64'({4'b1100, 16'h0106}));
      @(negedge clk); rst = 1'b0;

      step("wr_r1", 16'h0000, 16'h0000, 1'b1, 4'h1, 16'h0005, 4'h0, 1'b0);
      step("wr_r2", 16'h0000, 16'h0000, 1'b1, 4'h2, 16'h0003, 4'h0, 1'b0);
      step("rtype", 16'h0120, 16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      check("rtype_op1", 64'(idexOp1), 64'h5);
      check("rtype_op2", 64'(idexOp2), 64'h3);
      step("wthru", 16'h0120, 16'h0000, 1'b1, 4'h2, 16'h00AA, 4'h0, 1'b0);
      check("wthru_op2", 64'(idexOp2), 64'hAA);

      step("lw", 16'h8130, 16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      step("lu_stall", 16'h0210, 16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      check("lu_pcwrite", 64'(ctl_seen[19:18]), 64'h0);
      step("lu_issue", 16'h0210, 16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);

      step("bz_taken", 16'h4304, 16'h0010, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      check("bz_tgt", 64'(ctl_seen), 64'({4'b1111, 16'h0018}));
      step("wr_r3", 16'h0000, 16'h0000, 1'b1, 4'h3, 16'h0001, 4'h0, 1'b0);
      step("bz_nt", 16'h4304, 16'h0010, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      check("bz_nt_sel", 64'(ctl_seen[17:16]), 64'h0);
      step("bnz_taken", 16'h5304, 16'h0010, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);

      step("lw_r3", 16'h8330, 16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      step("bz_ex", 16'h4304, 16'h0020, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      step("bz_mem", 16'h4304, 16'h0020, 1'b0, 4'h0, 16'h0000, 4'h3, 1'b1);
      step("bz_wb", 16'h4304, 16'h0020, 1'b1, 4'h3, 16'h0000, 4'h0, 1'b0);
      check("bz_wb_sel", 64'(ctl_seen[17:16]), 64'h3);

      step("r_to_r3", 16'h0314, 16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      step("bz_exalu", 16'h44FE, 16'h0030, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      step("sw", 16'hB127, 16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      step("jmp", 16'hCFFE, 16'h0002, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      check("jmp_wrap", 64'(ctl_seen[15:0]), 64'hFFFE);
      step("nop", 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);

      step("lw_again", 16'h8130, 16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      @(negedge clk);
      InstIn = 16'h0210;
      #1;
      check("pre_rst_stall", 64'(pcWrite), 64'h0);
      rst = 1'b1;
      #1;
      check("mid_rst_idex", w_obs, 64'h0);
      check("mid_rst_pcwrite", 64'({pcWrite, enable}), 64'h3);
      @(posedge clk); #1;
      check("held_rst_idex", w_obs, 64'h0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
      m_idex = '0;
      step("post_rst", 16'h0120, 16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0);
      check("post_rst_op1", 64'(idexOp1), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
